alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control stage directly upstream of the ALU: fetches instructions from a synchronous program ROM, decodes them, and drives the ALU opcode, enable and operands.
- Owns the accumulator (ALU first operand), the carry and zero flags, and the program counter.
- Executes conditional and unconditional jumps and a HALT instruction; it is the top-level sequencer of the lab CPU datapath.

Parameters:
- DATA_WIDTH, 8, accumulator, immediate and ALU operand width.
- OPCODE_WIDTH, 3, ALU opcode width.
- PC_WIDTH, 8, program counter and ROM address width.
- INSTR_WIDTH, 12, instruction word width; fixed at 4 + DATA_WIDTH.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins execution from PC=0; sampled only in IDLE.
- prog_addr  out  PC_WIDTH  ROM address (current PC).
- prog_data  in  INSTR_WIDTH  ROM data, valid one cycle after prog_addr.
- op_code  out  OPCODE_WIDTH  ALU operation.
- ALU_ce  out  1  ALU enable, high only in EXECUTE of an ALU-class instruction.
- carry_we  out  1  high in EXECUTE of ADD.
- alu_a  out  DATA_WIDTH  accumulator, drives ALU i_1.
- alu_b  out  DATA_WIDTH  immediate field, drives ALU i_2.
- alu_result  in  DATA_WIDTH  ALU o_main.
- alu_carry  in  1  ALU carry_out.
- zero_flag  out  1  registered zero flag.
- carry_flag  out  1  registered carry flag.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset (async, any state, including mid-instruction): state=IDLE, PC=0, IR=0, acc=0, both flags=0.
  - All outputs are 0 during and after reset: halted=0, ALU_ce=0, carry_we=0, op_code=0, alu_b=0.
- Instruction format: [11:8] class/opcode nibble, [7:0] imm.
  - Nibble 0xxx: ALU op, op_code=nibble[2:0].
  - 0x8 JMP, 0x9 JZ, 0xA JC, 0xF HALT; 0xB–0xE are NOP.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, HALTED.
  - IDLE -> FETCH when start=1; PC cleared to 0 on that transition.
  - FETCH: prog_addr=PC; -> DECODE.
  - DECODE: IR<=prog_data; -> EXECUTE.
  - EXECUTE: outputs are combinational from IR. End-of-cycle updates:
    - ALU op: acc<=alu_result; zero_flag<=(alu_result==0); carry_flag<=alu_carry on ADD only, otherwise carry_flag unchanged; PC<=PC+1; -> FETCH.
    - JMP: PC<=imm[PC_WIDTH-1:0].
    - JZ: PC<=imm if zero_flag, else PC+1.
    - JC: PC<=imm if carry_flag, else PC+1.
    - NOP: PC+1.
    - Jumps and NOP: acc and flags unchanged; -> FETCH.
    - HALT: -> HALTED; PC and acc frozen.
  - HALTED: sticky until rst_n; start ignored; halted=1.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE), no pipelining.
- PC increments modulo 2^PC_WIDTH: 0xFF+1 -> 0x00.
- Outside EXECUTE: ALU_ce=0 and carry_we=0; op_code and alu_b hold IR-derived values.
- start asserted while not in IDLE is ignored.

Decomposition:
- alu_pkg additions:
  - seq_state_t enum (IDLE, FETCH, DECODE, EXECUTE, HALTED).
  - Control nibble constants: CTRL_JMP=4'h8, CTRL_JZ=4'h9, CTRL_JC=4'hA, CTRL_HALT=4'hF.
  - INSTR_WIDTH localparam.
  - instruction_code enum encoding: ADD=0, SUBTRACT=1, AND_OP=2, OR_OP=3, XOR_OP=4, NOT_OP=5, LOAD=6.
- One sub-module: seq_decoder, combinational. IR -> is_alu, op_code, jump type, is_halt, imm.

Test Plan:
- ROM {0: 0x605 LOAD 5, 1: 0x003 ADD 3, 2: 0xF00}, start pulse -> acc=0x08, carry=0, zero=0, halted=1; PC frozen at 2; ALU_ce high exactly 2 cycles.
- {LOAD 0xF0, ADD 0x20, JC 0x07, ..., 7: HALT} -> acc=0x10, carry_flag=1, PC reaches 0x07, halted=1.
- {LOAD 5, SUB 5, JZ 0x10, ..., 0x10: HALT} -> zero_flag=1, jump taken. Variant SUB 4 -> acc=0x01, zero_flag=0, falls through to PC=3.
- {0: JMP 0xFF, 0xFF: NOP, 0x00 reached again} -> prog_addr sequence 0x00, 0xFF, 0x00; acc and flags unchanged.
- rst_n low in the middle of EXECUTE of ADD -> immediate return to IDLE: acc=0, flags=0, PC=0, ALU_ce=0, with no clock edge required.
- In HALTED, pulse start -> state stays HALTED; in IDLE, hold start=0 -> no prog_addr activity, ALU_ce=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the lab CPU sequencer: FSM states, ALU opcodes,
// jump classes and the control-nibble encodings of the instruction word.
package alu_pkg;

   localparam int INSTR_WIDTH = 12;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      HALTED
   } seq_state_t;

   typedef enum logic [2:0] {
      ADD      = 3'd0,
      SUBTRACT = 3'd1,
      AND_OP   = 3'd2,
      OR_OP    = 3'd3,
      XOR_OP   = 3'd4,
      NOT_OP   = 3'd5,
      LOAD     = 3'd6
   } instruction_code;

   typedef enum logic [1:0] {
      JUMP_NONE,
      JUMP_ALWAYS,
      JUMP_ZERO,
      JUMP_CARRY
   } jump_t;

   localparam logic [3:0] CTRL_JMP  = 4'h8;
   localparam logic [3:0] CTRL_JZ   = 4'h9;
   localparam logic [3:0] CTRL_JC   = 4'hA;
   localparam logic [3:0] CTRL_HALT = 4'hF;

endpackage

// File: rtl/alu_sequencer_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// ALU-class flag, opcode, jump class, halt flag and immediate.
module seq_decoder
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 3
) (
   input  logic [DATA_WIDTH+3:0]   ir,
   output logic                    is_alu,
   output logic [OPCODE_WIDTH-1:0] op_code,
   output jump_t                   jump,
   output logic                    is_halt,
   output logic [DATA_WIDTH-1:0]   imm
);

   logic [3:0] nibble;

   assign nibble  = ir[DATA_WIDTH+3 -: 4];
   assign imm     = ir[DATA_WIDTH-1:0];
   assign is_alu  = ~nibble[3];
   assign op_code = OPCODE_WIDTH'(nibble[2:0]);
   assign is_halt = (nibble == CTRL_HALT);

   // Nibbles 0xB..0xE fall through to JUMP_NONE and behave as NOP.
   always_comb begin
      jump = JUMP_NONE;
      case (nibble)
         CTRL_JMP: jump = JUMP_ALWAYS;
         CTRL_JZ:  jump = JUMP_ZERO;
         CTRL_JC:  jump = JUMP_CARRY;
         default:  jump = JUMP_NONE;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Top-level sequencer of the lab CPU: fetch/decode/execute FSM that owns the
// program counter, instruction register, accumulator and carry/zero flags.
module alu_sequencer #(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 3,
   parameter int PC_WIDTH     = 8,
   parameter int INSTR_WIDTH  = 4 + DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic [PC_WIDTH-1:0]     prog_addr,
   input  logic [INSTR_WIDTH-1:0]  prog_data,
   output logic [OPCODE_WIDTH-1:0] op_code,
   output logic                    ALU_ce,
   output logic                    carry_we,
   output logic [DATA_WIDTH-1:0]   alu_a,
   output logic [DATA_WIDTH-1:0]   alu_b,
   input  logic [DATA_WIDTH-1:0]   alu_result,
   input  logic                    alu_carry,
   output logic                    zero_flag,
   output logic                    carry_flag,
   output logic                    halted
);

   import alu_pkg::*;

   seq_state_t               state_reg, state_next;
   logic [PC_WIDTH-1:0]      pc_reg, pc_next;
   logic [INSTR_WIDTH-1:0]   ir_reg, ir_next;
   logic [DATA_WIDTH-1:0]    acc_reg, acc_next;
   logic                     zero_reg, zero_next;
   logic                     carry_reg, carry_next;

   logic                     dec_is_alu;
   logic                     dec_is_halt;
   logic [OPCODE_WIDTH-1:0]  dec_op;
   jump_t                    dec_jump;
   logic [DATA_WIDTH-1:0]    dec_imm;

   logic [PC_WIDTH-1:0]      pc_inc;
   logic [PC_WIDTH-1:0]      imm_pc;
   logic                     in_execute;
   logic                     is_add;

   seq_decoder #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_decoder (
      .ir      (ir_reg),
      .is_alu  (dec_is_alu),
      .op_code (dec_op),
      .jump    (dec_jump),
      .is_halt (dec_is_halt),
      .imm     (dec_imm)
   );

   assign pc_inc     = pc_reg + PC_WIDTH'(1);
   assign imm_pc     = PC_WIDTH'(dec_imm);
   assign in_execute = (state_reg == EXECUTE);
   assign is_add     = dec_is_alu && (dec_op == OPCODE_WIDTH'(ADD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         ir_reg    <= '0;
         acc_reg   <= '0;
         zero_reg  <= 1'b0;
         carry_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         acc_reg   <= acc_next;
         zero_reg  <= zero_next;
         carry_reg <= carry_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      acc_next   = acc_reg;
      zero_next  = zero_reg;
      carry_next = carry_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               pc_next    = '0;
            end
         end
         FETCH:  state_next = DECODE;
         DECODE: begin
            ir_next    = prog_data;
            state_next = EXECUTE;
         end
         EXECUTE: begin
            if (dec_is_halt) begin
               state_next = HALTED;
            end else begin
               state_next = FETCH;
               pc_next    = pc_inc;
               if (dec_is_alu) begin
                  acc_next  = alu_result;
                  zero_next = (alu_result == '0);
                  if (is_add) begin
                     carry_next = alu_carry;
                  end
               end
               // Conditional jumps test the flags as they stood before this instruction.
               case (dec_jump)
                  JUMP_ALWAYS: pc_next = imm_pc;
                  JUMP_ZERO:   if (zero_reg)  pc_next = imm_pc;
                  JUMP_CARRY:  if (carry_reg) pc_next = imm_pc;
                  default:     ;
               endcase
            end
         end
         HALTED:  state_next = HALTED;
         default: state_next = IDLE;
      endcase
   end

   assign prog_addr  = pc_reg;
   assign op_code    = dec_op;
   assign alu_a      = acc_reg;
   assign alu_b      = dec_imm;
   assign ALU_ce     = in_execute && dec_is_alu;
   assign carry_we   = in_execute && is_add;
   assign zero_flag  = zero_reg;
   assign carry_flag = carry_reg;
   assign halted     = (state_reg == HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a synchronous program ROM
// and a behavioural ALU wired around the sequencer.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  prog_addr;
   logic [11:0] prog_data;
   logic [2:0]  op_code;
   logic        ALU_ce;
   logic        carry_we;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_result;
   logic        alu_carry;
   logic        zero_flag;
   logic        carry_flag;
   logic        halted;

   logic [11:0] rom [0:255];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ce_total = 0;
   int          cwe_total = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .op_code    (op_code),
      .ALU_ce     (ALU_ce),
      .carry_we   (carry_we),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .halted     (halted)
   );

   always @(posedge clk) prog_data <= rom[prog_addr];

   // Behavioural ALU; SUB reports carry as "no borrow" so a stray flag update is visible.
   logic [8:0] alu_wide;
   always_comb begin
      alu_wide = 9'h000;
      case (op_code)
         3'd0: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
         3'd2: alu_wide = {1'b0, alu_a & alu_b};
         3'd3: alu_wide = {1'b0, alu_a | alu_b};
         3'd4: alu_wide = {1'b0, alu_a ^ alu_b};
         3'd5: alu_wide = {1'b0, ~alu_a};
         3'd6: alu_wide = {1'b0, alu_b};
         default: alu_wide = 9'h000;
      endcase
      alu_result = alu_wide[7:0];
      alu_carry  = alu_wide[8];
   end

   always @(negedge clk) begin
      if (ALU_ce)   ce_total  <= ce_total + 1;
      if (carry_we) cwe_total <= cwe_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (!halted && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, halted}, 32'd1);
   endtask

   initial begin
      int ce0, cwe0, bad, n;
      logic [7:0] seen [$];

      rst_n = 1'b0;
      start = 1'b0;
      clear_rom();

      // Program 1: LOAD 5, ADD 3, HALT
      rom[0] = 12'h605;
      rom[1] = 12'h003;
      rom[2] = 12'hF00;
      apply_reset();
      check("rst_halted",   {31'd0, halted},   32'd0);
      check("rst_alu_ce",   {31'd0, ALU_ce},   32'd0);
      check("rst_carry_we", {31'd0, carry_we}, 32'd0);
      check("rst_op_code",  {29'd0, op_code},  32'd0);
      check("rst_alu_b",    {24'd0, alu_b},    32'd0);
      check("rst_acc",      {24'd0, alu_a},    32'd0);
      check("rst_pc",       {24'd0, prog_addr}, 32'd0);
      check("rst_flags",    {30'd0, zero_flag, carry_flag}, 32'd0);

      // Idle with start low: nothing moves
      ce0 = ce_total;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (prog_addr != 8'h00 || ALU_ce) bad++;
      end
      check("idle_quiet",  bad, 0);
      check("idle_ce_cnt", ce_total - ce0, 0);

      ce0  = ce_total;
      cwe0 = cwe_total;
      pulse_start();
      wait_halt("p1_halted");
      check("p1_acc",      {24'd0, alu_a},     32'h08);
      check("p1_carry",    {31'd0, carry_flag}, 32'd0);
      check("p1_zero",     {31'd0, zero_flag},  32'd0);
      check("p1_pc",       {24'd0, prog_addr}, 32'h02);
      check("p1_ce_cnt",   ce_total - ce0,     2);
      check("p1_cwe_cnt",  cwe_total - cwe0,   1);

      // start while halted is ignored
      pulse_start();
      repeat (6) @(negedge clk);
      check("halt_sticky", {31'd0, halted},    32'd1);
      check("halt_pc",     {24'd0, prog_addr}, 32'h02);
      check("halt_acc",    {24'd0, alu_a},     32'h08);
      check("halt_ce_cnt", ce_total - ce0,     2);

      // Program 2: LOAD F0, ADD 20 (carry out), JC 07
      clear_rom();
      rom[0] = 12'h6F0;
      rom[1] = 12'h020;
      rom[2] = 12'hA07;
      for (int i = 3; i < 7; i++) rom[i] = 12'h6AA;
      rom[7] = 12'hF00;
      apply_reset();
      pulse_start();
      wait_halt("p2_halted");
      check("p2_acc",   {24'd0, alu_a},      32'h10);
      check("p2_carry", {31'd0, carry_flag}, 32'd1);
      check("p2_zero",  {31'd0, zero_flag},  32'd0);
      check("p2_pc",    {24'd0, prog_addr},  32'h07);

      // Program 3a: LOAD 5, SUB 5, JZ 10 taken
      clear_rom();
      rom[0] = 12'h605;
      rom[1] = 12'h105;
      rom[2] = 12'h910;
      rom[3] = 12'hF00;
      rom[8'h10] = 12'hF00;
      apply_reset();
      pulse_start();
      wait_halt("p3a_halted");
      check("p3a_acc",   {24'd0, alu_a},      32'h00);
      check("p3a_zero",  {31'd0, zero_flag},  32'd1);
      check("p3a_carry", {31'd0, carry_flag}, 32'd0);
      check("p3a_pc",    {24'd0, prog_addr},  32'h10);

      // Program 3b: SUB 4 leaves 1, JZ falls through
      rom[1] = 12'h104;
      apply_reset();
      pulse_start();
      wait_halt("p3b_halted");
      check("p3b_acc",  {24'd0, alu_a},     32'h01);
      check("p3b_zero", {31'd0, zero_flag}, 32'd0);
      check("p3b_pc",   {24'd0, prog_addr}, 32'h03);

      // Program 4: JMP FF, NOP at FF wraps PC to 00
      clear_rom();
      rom[0]     = 12'h8FF;
      rom[8'hFF] = 12'hB00;
      apply_reset();
      ce0 = ce_total;
      pulse_start();
      seen.delete();
      seen.push_back(prog_addr);
      repeat (8) begin
         @(negedge clk);
         if (prog_addr != seen[$]) seen.push_back(prog_addr);
      end
      check("p4_seq_len", seen.size(), 3);
      check("p4_seq0", {24'd0, seen[0]}, 32'h00);
      check("p4_seq1", {24'd0, seen[1]}, 32'hFF);
      check("p4_seq2", {24'd0, seen[2]}, 32'h00);
      check("p4_acc",    {24'd0, alu_a}, 32'h00);
      check("p4_flags",  {30'd0, zero_flag, carry_flag}, 32'd0);
      check("p4_halted", {31'd0, halted}, 32'd0);
      check("p4_ce_cnt", ce_total - ce0, 0);

      // Program 5: LOAD 0, ADD 3; async reset in the middle of the ADD execute cycle
      clear_rom();
      rom[0] = 12'h600;
      rom[1] = 12'h003;
      apply_reset();
      pulse_start();
      n = 0;
      while (!(ALU_ce && carry_we) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("p5_in_add",  {30'd0, ALU_ce, carry_we}, 32'd3);
      check("p5_pre_zero", {31'd0, zero_flag}, 32'd1);
      check("p5_pre_pc",   {24'd0, prog_addr}, 32'h01);
      rst_n = 1'b0;
      #1;
      check("p5_rst_acc",   {24'd0, alu_a},     32'h00);
      check("p5_rst_flags", {30'd0, zero_flag, carry_flag}, 32'd0);
      check("p5_rst_pc",    {24'd0, prog_addr}, 32'h00);
      check("p5_rst_ce",    {30'd0, ALU_ce, carry_we}, 32'd0);
      check("p5_rst_alu_b", {24'd0, alu_b},     32'h00);
      check("p5_rst_halt",  {31'd0, halted},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
